// File: rtl/aes_byte_loader_if.sv
// Bundle between upstream byte source, aes_byte_loader and the byte-serial AES core.
// The master side is the surrounding system and the slave side is the loader.
// KEY_REUSE_EN adds the key_reuse input.
interface aes_byte_loader_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] in_key;
`ifdef KEY_REUSE_EN
  logic       key_reuse;
`endif
  logic       core_start;
  logic       core_valid;
  logic [7:0] core_data;
  logic [7:0] core_key;
  logic       core_done;

  modport master (
`ifdef KEY_REUSE_EN
    output key_reuse,
`endif
    output in_valid, in_data, in_key, core_done,
    input  in_ready, core_start, core_valid, core_data, core_key
  );

  modport slave (
`ifdef KEY_REUSE_EN
    input  key_reuse,
`endif
    input  in_valid, in_data, in_key, core_done,
    output in_ready, core_start, core_valid, core_data, core_key
  );
endinterface

// File: rtl/aes_byte_loader.sv
// Buffers one block of plaintext/key byte pairs and replays it to the AES core as an unbroken
// burst, then waits for core_done or a timeout. Optional feature macro: KEY_REUSE_EN.
module aes_byte_loader #(
  parameter int unsigned NBYTES  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  aes_byte_loader_if.slave bus,
  output logic             busy,
  output logic             err
);
  localparam int unsigned     CntW       = $clog2(NBYTES);
  localparam logic [CntW-1:0] LastIdx    = CntW'(NBYTES - 1);
  localparam logic [7:0]      TimeoutVal = 8'(TIMEOUT);

  typedef enum logic [1:0] {StFill, StBurst, StWait} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      timer_q, timer_d;
  logic            core_start_q, core_start_d;
  logic            core_valid_q, core_valid_d;
  logic [7:0]      core_data_q, core_data_d;
  logic [7:0]      core_key_q, core_key_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic [7:0]      dbuf_q [NBYTES];
  logic [7:0]      dbuf_d [NBYTES];
  logic [7:0]      kbuf_q [NBYTES];
  logic [7:0]      kbuf_d [NBYTES];
  logic            in_ready;
  logic            xfer;
  logic            kbuf_we;

  assign in_ready     = (state_q == StFill);
  assign xfer         = bus.in_valid & in_ready;
  assign bus.in_ready = in_ready;

`ifdef KEY_REUSE_EN
  logic reuse_q, reuse_d;

  // The reuse decision is taken on the first pair and held for the rest of the block.
  always_comb begin
    reuse_d = reuse_q;
    if (xfer && cnt_q == '0) begin
      reuse_d = bus.key_reuse;
    end
  end

  assign kbuf_we = xfer & ~((cnt_q == '0) ? bus.key_reuse : reuse_q);
`else
  assign kbuf_we = xfer;
`endif

  always_comb begin
    dbuf_d = dbuf_q;
    kbuf_d = kbuf_q;
    if (xfer) begin
      dbuf_d[cnt_q] = bus.in_data;
    end
    if (kbuf_we) begin
      kbuf_d[cnt_q] = bus.in_key;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    timer_d      = timer_q;
    core_start_d = 1'b0;
    core_valid_d = 1'b0;
    core_data_d  = 8'h00;
    core_key_d   = 8'h00;
    err_d        = err_q;
    unique case (state_q)
      StFill: begin
        if (xfer) begin
          if (cnt_q == LastIdx) begin
            cnt_d   = '0;
            state_d = StBurst;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StBurst: begin
        core_valid_d = 1'b1;
        core_start_d = (cnt_q == '0);
        core_data_d  = dbuf_q[cnt_q];
        core_key_d   = kbuf_q[cnt_q];
        if (cnt_q == LastIdx) begin
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWait: begin
        // core_done takes priority over a coincident timeout.
        if (bus.core_done) begin
          state_d = StFill;
          timer_d = 8'h00;
        end else if (timer_q == TimeoutVal) begin
          err_d   = 1'b1;
          state_d = StFill;
          timer_d = 8'h00;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = StFill;
    endcase
    busy_d = (state_d != StFill);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StFill;
      cnt_q        <= '0;
      timer_q      <= 8'h00;
      core_start_q <= 1'b0;
      core_valid_q <= 1'b0;
      core_data_q  <= 8'h00;
      core_key_q   <= 8'h00;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef KEY_REUSE_EN
      reuse_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      core_start_q <= core_start_d;
      core_valid_q <= core_valid_d;
      core_data_q  <= core_data_d;
      core_key_q   <= core_key_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
`ifdef KEY_REUSE_EN
      reuse_q      <= reuse_d;
`endif
    end
  end

  // Block buffers keep their contents across reset.
  always_ff @(posedge clk) begin
    dbuf_q <= dbuf_d;
    kbuf_q <= kbuf_d;
  end

  assign bus.core_start = core_start_q;
  assign bus.core_valid = core_valid_q;
  assign bus.core_data  = core_data_q;
  assign bus.core_key   = core_key_q;
  assign busy           = busy_q;
  assign err            = err_q;
endmodule

// File: tb/tb_aes_byte_loader.sv
// Self-checking bench for aes_byte_loader: random byte pairs and gap patterns, with the
// expected burst taken straight from the block the bench itself sent.
module tb_aes_byte_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic err;

  aes_byte_loader_if bus ();

  aes_byte_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] pd [16];
  logic [7:0] pk [16];
  logic [7:0] got_d [$];
  logic [7:0] got_k [$];
  int nstart, start_first, first_lat, runs, zero_bad;
  logic last_rdy;
`ifdef KEY_REUSE_EN
  bit reuse_blk;
  logic [7:0] key_model [16];
`endif

  task automatic rand_block();
    for (int i = 0; i < 16; i++) begin
      pd[i] = 8'($urandom);
      pk[i] = 8'($urandom);
    end
  endtask

  // mode 0: continuous, 1: alternating 1/0 (with stray core_done), 2: random gaps.
  task automatic send_pairs(input int mode);
    int  i = 0;
    int  guard = 0;
    bit  v;
    bit  rdy;
    bit  tog = 1'b1;
    while (i < 16 && guard < 400) begin
      case (mode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = !tog; end
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      rdy = bus.in_ready;
      bus.in_valid  = v;
      bus.in_data   = v ? pd[i] : 8'($urandom);
      bus.in_key    = v ? pk[i] : 8'($urandom);
      bus.core_done = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
`ifdef KEY_REUSE_EN
      bus.key_reuse = reuse_blk;
`endif
      @(negedge clk);
      if (v && rdy) i++;
      guard++;
    end
    bus.in_valid  = 1'b0;
    bus.core_done = 1'b0;
    last_rdy = bus.in_ready;
    checks++;
    if (i != 16) begin
      failures++;
      $display("FAIL send_pairs: accepted %0d pairs, required 16", i);
    end
  endtask

  task automatic collect();
    bit prev = 1'b0;
    got_d.delete();
    got_k.delete();
    nstart = 0; start_first = 0; first_lat = -1; runs = 0; zero_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.core_start === 1'b1) begin
        nstart++;
        if (bus.core_valid === 1'b1 && !prev) start_first++;
      end
      if (bus.core_valid === 1'b1) begin
        if (!prev) begin
          runs++;
          if (first_lat < 0) first_lat = c;
        end
        got_d.push_back(bus.core_data);
        got_k.push_back(bus.core_key);
      end else if (bus.core_data !== 8'h00 || bus.core_key !== 8'h00) begin
        zero_bad++;
      end
      if (bus.core_valid !== 1'b1 && prev) break;
      prev = (bus.core_valid === 1'b1);
    end
  endtask

  // Called while WAITing; optionally holds the next block's first pair on the input.
  task automatic release_done(input int delay, input bit hold);
    for (int c = 0; c < delay; c++) begin
      if (hold) begin
        bus.in_valid = 1'b1; bus.in_data = pd[0]; bus.in_key = pk[0];
`ifdef KEY_REUSE_EN
        bus.key_reuse = reuse_blk;
`endif
      end
      @(negedge clk);
    end
    bus.core_done = 1'b1;
    @(negedge clk);
    bus.core_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: got rdy=%b busy=%b err=%b, required 1 0 0",
               bus.in_ready, busy, err);
    end
    checks++;
    if ({bus.core_start, bus.core_valid, bus.core_data, bus.core_key} !== 18'h0) begin
      failures++;
      $display("FAIL reset_core: got start=%b valid=%b data=%h key=%h, required all 0",
               bus.core_start, bus.core_valid, bus.core_data, bus.core_key);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      pd[i] = 8'(i * 17);
      pk[i] = 8'(i);
    end
    send_pairs(0);
    checks++;
    if (last_rdy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ready_drop: got in_ready=%b, required 0", last_rdy);
    end
    collect();
    checks++;
    if (got_d.size() != 16 || runs != 1 || first_lat != 1 || zero_bad != 0) begin
      failures++;
      $display("FAIL b2b_shape: got n=%0d runs=%0d lat=%0d zb=%0d, required 16 1 1 0",
               got_d.size(), runs, first_lat, zero_bad);
    end
    checks++;
    if (nstart != 1 || start_first != 1) begin
      failures++;
      $display("FAIL b2b_start: got pulses=%0d at_first=%0d, required 1 1", nstart, start_first);
    end
    for (int j = 0; j < got_d.size() && j < 16; j++) begin
      checks++;
      if ({got_d[j], got_k[j]} !== {pd[j], pk[j]}) begin
        failures++;
        $display("FAIL b2b_byte%0d: got %h/%h, required %h/%h", j, got_d[j], got_k[j], pd[j], pk[j]);
      end
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_wait_busy: got busy=%b, required 1", busy);
    end
    release_done($urandom_range(0, 30), 1'b0);
    checks++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done_fill: got rdy=%b busy=%b, required 1 0", bus.in_ready, busy);
    end
  endtask

  task automatic test_gaps();
    send_pairs(1);
    collect();
    checks++;
    if (got_d.size() != 16 || runs != 1 || first_lat != 1 || nstart != 1 || start_first != 1) begin
      failures++;
      $display("FAIL gaps_shape: got n=%0d runs=%0d lat=%0d starts=%0d/%0d, required 16 1 1 1/1",
               got_d.size(), runs, first_lat, nstart, start_first);
    end
    for (int j = 0; j < got_d.size() && j < 16; j++) begin
      checks++;
      if ({got_d[j], got_k[j]} !== {8'(j * 17), 8'(j)}) begin
        failures++;
        $display("FAIL gaps_byte%0d: got %h/%h, required %h/%h", j, got_d[j], got_k[j],
                 8'(j * 17), 8'(j));
      end
    end
  endtask

  task automatic test_done_fips();
    logic [127:0] kv = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    logic [127:0] pv = 128'h3243f6a8885a308d313198a2e0370734;
    for (int i = 0; i < 16; i++) begin
      pk[i] = kv[127 - 8 * i -: 8];
      pd[i] = pv[127 - 8 * i -: 8];
    end
    release_done($urandom_range(0, 60), 1'b1);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL fips_ready_after_done: got %b, required 1", bus.in_ready);
    end
    send_pairs(0);
    collect();
    checks++;
    if (got_d.size() != 16 || runs != 1) begin
      failures++;
      $display("FAIL fips_shape: got n=%0d runs=%0d, required 16 1", got_d.size(), runs);
    end else begin
      checks++;
      if ({got_k[0], got_d[0], got_k[15], got_d[15]} !== 32'h2b323c34) begin
        failures++;
        $display("FAIL fips_ends: got %h/%h..%h/%h, required 2b/32..3c/34",
                 got_k[0], got_d[0], got_k[15], got_d[15]);
      end
    end
    for (int j = 0; j < got_d.size() && j < 16; j++) begin
      checks++;
      if ({got_d[j], got_k[j]} !== {pd[j], pk[j]}) begin
        failures++;
        $display("FAIL fips_byte%0d: got %h/%h, required %h/%h", j, got_d[j], got_k[j], pd[j], pk[j]);
      end
    end
  endtask

  // WAIT lasts 256 cycles (timer 0..255); done on the last one must beat the timeout.
  task automatic test_done_at_timeout();
    int early = 0;
    release_done(3, 1'b0);
    rand_block();
    send_pairs(2);
    collect();
    for (int j = 0; j < got_d.size() && j < 16; j++) begin
      checks++;
      if ({got_d[j], got_k[j]} !== {pd[j], pk[j]}) begin
        failures++;
        $display("FAIL edge_byte%0d: got %h/%h, required %h/%h", j, got_d[j], got_k[j], pd[j], pk[j]);
      end
    end
    for (int k = 0; k < 254; k++) begin
      @(negedge clk);
      if (err !== 1'b0 || busy !== 1'b1) early++;
    end
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL edge_wait_hold: got %0d bad cycles, required 0", early);
    end
    bus.core_done = 1'b1;
    @(negedge clk);
    bus.core_done = 1'b0;
    checks++;
    if (err !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL edge_done_wins: got err=%b rdy=%b, required 0 1", err, bus.in_ready);
    end
  endtask

  task automatic test_timeout();
    int early = 0;
    rand_block();
    send_pairs(2);
    collect();
    checks++;
    if (got_d.size() != 16) begin
      failures++;
      $display("FAIL to_burst_len: got %0d, required 16", got_d.size());
    end
    for (int k = 0; k < 254; k++) begin
      @(negedge clk);
      if (err !== 1'b0 || busy !== 1'b1) early++;
    end
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL to_early: got %0d bad cycles, required 0", early);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL to_expire: got err=%b busy=%b rdy=%b, required 1 0 1",
               err, busy, bus.in_ready);
    end
    rand_block();
    send_pairs(0);
    collect();
    release_done(5, 1'b0);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL to_sticky: got err=%b, required 1", err);
    end
    for (int j = 0; j < got_d.size() && j < 16; j++) begin
      checks++;
      if ({got_d[j], got_k[j]} !== {pd[j], pk[j]}) begin
        failures++;
        $display("FAIL to_next_byte%0d: got %h/%h, required %h/%h", j, got_d[j], got_k[j],
                 pd[j], pk[j]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    rand_block();
    send_pairs(0);
    repeat (8) @(negedge clk);
    checks++;
    if (bus.core_valid !== 1'b1 || {bus.core_data, bus.core_key} !== {pd[7], pk[7]}) begin
      failures++;
      $display("FAIL mid_byte7: got v=%b %h/%h, required 1 %h/%h",
               bus.core_valid, bus.core_data, bus.core_key, pd[7], pk[7]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.core_valid, bus.core_data, bus.core_key} !== 17'h0 || bus.in_ready !== 1'b1 ||
        busy !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got v=%b d=%h k=%h rdy=%b busy=%b err=%b, required 0 0 0 1 0 0",
               bus.core_valid, bus.core_data, bus.core_key, bus.in_ready, busy, err);
    end
    rst_n = 1'b1;
    rand_block();
    send_pairs(2);
    collect();
    checks++;
    if (got_d.size() != 16 || nstart != 1 || start_first != 1) begin
      failures++;
      $display("FAIL mid_restart_shape: got n=%0d starts=%0d/%0d, required 16 1/1",
               got_d.size(), nstart, start_first);
    end
    for (int j = 0; j < got_d.size() && j < 16; j++) begin
      checks++;
      if ({got_d[j], got_k[j]} !== {pd[j], pk[j]}) begin
        failures++;
        $display("FAIL mid_restart_byte%0d: got %h/%h, required %h/%h", j, got_d[j], got_k[j],
                 pd[j], pk[j]);
      end
    end
    release_done($urandom_range(0, 20), 1'b0);
  endtask

  task automatic test_random_blocks();
    for (int b = 0; b < 3; b++) begin
      rand_block();
      if (b > 0) begin
        release_done($urandom_range(0, 40), 1'b1);
        checks++;
        if (bus.in_ready !== 1'b1) begin
          failures++;
          $display("FAIL rnd%0d_ready: got %b, required 1", b, bus.in_ready);
        end
      end
      send_pairs(2);
      collect();
      checks++;
      if (got_d.size() != 16 || runs != 1 || first_lat != 1 || zero_bad != 0) begin
        failures++;
        $display("FAIL rnd%0d_shape: got n=%0d runs=%0d lat=%0d zb=%0d, required 16 1 1 0",
                 b, got_d.size(), runs, first_lat, zero_bad);
      end
      for (int j = 0; j < got_d.size() && j < 16; j++) begin
        checks++;
        if ({got_d[j], got_k[j]} !== {pd[j], pk[j]}) begin
          failures++;
          $display("FAIL rnd%0d_byte%0d: got %h/%h, required %h/%h", b, j, got_d[j], got_k[j],
                   pd[j], pk[j]);
        end
      end
    end
    release_done(2, 1'b0);
  endtask

`ifdef KEY_REUSE_EN
  task automatic test_key_reuse();
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) begin
        pd[i] = 8'($urandom);
        pk[i] = (b == 0) ? 8'(i) : (b == 1) ? 8'hff : 8'($urandom);
      end
      reuse_blk = (b == 1);
      if (!reuse_blk) begin
        for (int i = 0; i < 16; i++) key_model[i] = pk[i];
      end
      send_pairs(2);
      collect();
      checks++;
      if (got_d.size() != 16) begin
        failures++;
        $display("FAIL kr%0d_len: got %0d, required 16", b, got_d.size());
      end
      for (int j = 0; j < got_d.size() && j < 16; j++) begin
        checks++;
        if ({got_d[j], got_k[j]} !== {pd[j], key_model[j]}) begin
          failures++;
          $display("FAIL kr%0d_byte%0d: got %h/%h, required %h/%h", b, j, got_d[j], got_k[j],
                   pd[j], key_model[j]);
        end
      end
      release_done($urandom_range(0, 10), 1'b0);
    end
    reuse_blk = 1'b0;
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_key    = 8'h00;
    bus.core_done = 1'b0;
`ifdef KEY_REUSE_EN
    bus.key_reuse = 1'b0;
    reuse_blk     = 1'b0;
`endif
    test_reset();
    test_back_to_back();
    test_gaps();
    test_done_fips();
    test_done_at_timeout();
    test_timeout();
    test_reset_mid_burst();
    test_random_blocks();
`ifdef KEY_REUSE_EN
    test_key_reuse();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
